usb_reg_bridge: RTL and testbench

//  Upstream neighbour of the trace register block: turns the CW305 SAM3U external-bus strobes (cen/rdn/wrn,

---
 rtl/usb_reg_bridge_pkg.sv | 16 +
 rtl/usb_reg_bridge_sync2.sv | 22 ++
 rtl/usb_reg_bridge.sv | 148 ++++++++++++++
 tb/tb_usb_reg_bridge.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_reg_bridge_pkg.sv
// Shared types for the USB host-bus to register bridge.
// FSM state encoding and default read latency.
package usb_reg_bridge_pkg;

  localparam int READ_DELAY_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_HOLD,
    S_WR,
    S_WR_WAIT,
    S_ERR
  } state_t;

endpackage

// File: rtl/usb_reg_bridge_sync2.sv
// 2-FF synchroniser, resets to 1 (strobes idle high).
// Ports: clk, rst_n (async low), d (async in), q (synced out).
module usb_reg_bridge_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_reg_bridge.sv
// Host external-bus strobes to single-clock register handshake.
// Ports: host bus (usb_*), register side (reg_*, data), O_bus_error.
module usb_reg_bridge
  import usb_reg_bridge_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_DELAY   = READ_DELAY_DEF
) (
  input  logic                               usb_clk,
  input  logic                               reset_n,
  input  logic [pADDR_WIDTH-1:0]             usb_addr,
  input  logic [7:0]                         usb_din,
  output logic [7:0]                         usb_dout,
  output logic                               usb_isout,
  input  logic                               usb_cen,
  input  logic                               usb_rdn,
  input  logic                               usb_wrn,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  output logic [7:0]                         write_data,
  input  logic [7:0]                         read_data,
  output logic                               reg_read,
  output logic                               reg_write,
  output logic                               reg_addrvalid,
  output logic                               O_bus_error
);

  localparam int CW =
    (pREAD_DELAY > 1) ? $clog2(pREAD_DELAY) : 1;
  localparam logic [CW-1:0] RD_LAST =
    CW'(pREAD_DELAY - 1);

  logic   cen_s;
  logic   rdn_s;
  logic   wrn_s;
  logic   rd_act;
  logic   wr_act;
  state_t state;
  logic [CW-1:0] rd_cnt;

  usb_reg_bridge_sync2 u_sync_cen (
    .clk   (usb_clk),
    .rst_n (reset_n),
    .d     (usb_cen),
    .q     (cen_s)
  );

  usb_reg_bridge_sync2 u_sync_rdn (
    .clk   (usb_clk),
    .rst_n (reset_n),
    .d     (usb_rdn),
    .q     (rdn_s)
  );

  usb_reg_bridge_sync2 u_sync_wrn (
    .clk   (usb_clk),
    .rst_n (reset_n),
    .d     (usb_wrn),
    .q     (wrn_s)
  );

  // cen high is folded in, so it behaves like strobe release
  assign rd_act = ~cen_s & ~rdn_s;
  assign wr_act = ~cen_s & ~wrn_s;

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rd_cnt        <= '0;
      usb_dout      <= '0;
      usb_isout     <= 1'b0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= '0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_addrvalid <= 1'b0;
      O_bus_error   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rd_act && wr_act) begin
            O_bus_error <= 1'b1;
            state       <= S_ERR;
          end else if (rd_act) begin
            reg_address <=
              usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt <=
              usb_addr[pBYTECNT_SIZE-1:0];
            reg_addrvalid <= 1'b1;
            reg_read      <= 1'b1;
            rd_cnt        <= '0;
            state         <= S_RD;
          end else if (wr_act) begin
            reg_address <=
              usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt <=
              usb_addr[pBYTECNT_SIZE-1:0];
            write_data    <= usb_din;
            reg_addrvalid <= 1'b1;
            state         <= S_WR;
          end
        end
        S_RD: begin
          if (!rd_act) begin
            reg_read      <= 1'b0;
            reg_addrvalid <= 1'b0;
            state         <= S_IDLE;
          end else if (rd_cnt == RD_LAST) begin
            usb_dout  <= read_data;
            usb_isout <= 1'b1;
            state     <= S_RD_HOLD;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        S_RD_HOLD: begin
          if (!rd_act) begin
            reg_read      <= 1'b0;
            reg_addrvalid <= 1'b0;
            usb_isout     <= 1'b0;
            state         <= S_IDLE;
          end
        end
        // data already latched: always commit the pulse
        S_WR: begin
          reg_write <= 1'b1;
          state     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          reg_write <= 1'b0;
          if (!wr_act) begin
            reg_addrvalid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_ERR: begin
          if (!rd_act && !wr_act) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed testbench for usb_reg_bridge.
// Drives host strobes, checks register handshake and read return.
module tb_usb_reg_bridge;

  logic        usb_clk = 1'b0;
  logic        reset_n;
  logic [20:0] usb_addr;
  logic [7:0]  usb_din;
  logic [7:0]  usb_dout;
  logic        usb_isout;
  logic        usb_cen;
  logic        usb_rdn;
  logic        usb_wrn;
  logic [13:0] reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic        O_bus_error;

  int n_cmp  = 0;
  int n_fail = 0;

  int wr_pulses  = 0;
  int av_bad     = 0;
  int rd_seen    = 0;
  int isout_seen = 0;
  logic [6:0] bc_q[$];

  logic       rd_q;
  logic [7:0] rd_val;

  always #5 usb_clk = ~usb_clk;

  usb_reg_bridge dut (
    .usb_clk       (usb_clk),
    .reset_n       (reset_n),
    .usb_addr      (usb_addr),
    .usb_din       (usb_din),
    .usb_dout      (usb_dout),
    .usb_isout     (usb_isout),
    .usb_cen       (usb_cen),
    .usb_rdn       (usb_rdn),
    .usb_wrn       (usb_wrn),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .O_bus_error   (O_bus_error)
  );

  // register-block model: data valid from the cycle after reg_read
  always @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) rd_q <= 1'b0;
    else          rd_q <= reg_read;
  end
  assign read_data = (reg_read && rd_q) ? rd_val : 8'h00;

  always @(negedge usb_clk) begin
    if (reg_write) begin
      wr_pulses++;
      bc_q.push_back(reg_bytecnt);
      if (!reg_addrvalid) av_bad++;
    end
    if (reg_read)  rd_seen = 1;
    if (usb_isout) isout_seen = 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge usb_clk);
  endtask

  task automatic do_write(input logic [20:0] a,
                          input logic [7:0] d,
                          input int len,
                          input int gap);
    usb_addr = a;
    usb_din  = d;
    usb_cen  = 1'b0;
    usb_wrn  = 1'b0;
    idle(len);
    usb_wrn  = 1'b1;
    usb_cen  = 1'b1;
    idle(gap);
  endtask

  task automatic test_reset;
    logic [41:0] v;
    reset_n  = 1'b0;
    usb_cen  = 1'b1;
    usb_rdn  = 1'b1;
    usb_wrn  = 1'b1;
    usb_addr = '0;
    usb_din  = '0;
    rd_val   = '0;
    idle(3);
    v = {usb_dout, usb_isout, reg_address,
         reg_bytecnt, write_data, reg_read,
         reg_write, reg_addrvalid, O_bus_error};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    reset_n = 1'b1;
    idle(3);
    v = {usb_dout, usb_isout, reg_address,
         reg_bytecnt, write_data, reg_read,
         reg_write, reg_addrvalid, O_bus_error};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h want 0", v);
    end
  endtask

  task automatic test_write;
    int p0;
    p0 = wr_pulses;
    do_write(21'h0C180, 8'hA5, 10, 6);
    n_cmp++;
    if (wr_pulses - p0 !== 1) begin
      n_fail++;
      $display("FAIL wr_pulse_cnt: got %0d want 1",
               wr_pulses - p0);
    end
    n_cmp++;
    if (reg_address !== 14'h0183) begin
      n_fail++;
      $display("FAIL wr_addr: got %h want 0183",
               reg_address);
    end
    n_cmp++;
    if (reg_bytecnt !== 7'h00) begin
      n_fail++;
      $display("FAIL wr_bytecnt: got %h want 00",
               reg_bytecnt);
    end
    n_cmp++;
    if (write_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_data: got %h want a5", write_data);
    end
    n_cmp++;
    if (reg_addrvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_av_clear: got %b want 0",
               reg_addrvalid);
    end
    usb_din  = 8'h3C;
    usb_addr = 21'h1FFFF;
    idle(3);
    n_cmp++;
    if ({reg_address, write_data} !== {14'h0183, 8'hA5}) begin
      n_fail++;
      $display("FAIL wr_latch_hold: got %h/%h want 0183/a5",
               reg_address, write_data);
    end
  endtask

  task automatic test_read;
    int t;
    int c;
    rd_val   = 8'h41;
    usb_addr = 21'h1ABCD;
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge usb_clk);
      t++;
      if (reg_read) break;
    end
    n_cmp++;
    if (t !== 3) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d want 3", t);
    end
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge usb_clk);
      c++;
      if (usb_isout) break;
    end
    n_cmp++;
    if (c !== 2) begin
      n_fail++;
      $display("FAIL isout_delay: got %0d want 2", c);
    end
    n_cmp++;
    if (usb_dout !== 8'h41) begin
      n_fail++;
      $display("FAIL rd_dout: got %h want 41", usb_dout);
    end
    n_cmp++;
    if ({reg_address, reg_bytecnt} !== {14'h0357, 7'h4D}) begin
      n_fail++;
      $display("FAIL rd_addr: got %h/%h want 0357/4d",
               reg_address, reg_bytecnt);
    end
    idle(3);
    n_cmp++;
    if ({usb_isout, reg_read, reg_addrvalid} !== 3'b111) begin
      n_fail++;
      $display("FAIL rd_hold: got %b want 111",
               {usb_isout, reg_read, reg_addrvalid});
    end
    usb_rdn = 1'b1;
    usb_cen = 1'b1;
    idle(4);
    n_cmp++;
    if ({usb_isout, reg_read, reg_addrvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_release: got %b want 000",
               {usb_isout, reg_read, reg_addrvalid});
    end
    n_cmp++;
    if (usb_dout !== 8'h41) begin
      n_fail++;
      $display("FAIL rd_dout_keep: got %h want 41", usb_dout);
    end
  endtask

  task automatic test_abort;
    rd_val     = 8'h5A;
    rd_seen    = 0;
    isout_seen = 0;
    usb_addr   = 21'h00080;
    usb_cen    = 1'b0;
    usb_rdn    = 1'b0;
    idle(2);
    usb_rdn    = 1'b1;
    usb_cen    = 1'b1;
    idle(6);
    n_cmp++;
    if (rd_seen !== 1) begin
      n_fail++;
      $display("FAIL abort_rd_seen: got %0d want 1", rd_seen);
    end
    n_cmp++;
    if (isout_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_isout: got %0d want 0", isout_seen);
    end
    n_cmp++;
    if (usb_dout !== 8'h41) begin
      n_fail++;
      $display("FAIL abort_dout: got %h want 41", usb_dout);
    end
    n_cmp++;
    if ({reg_read, reg_addrvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 00",
               {reg_read, reg_addrvalid});
    end
  endtask

  task automatic test_bus_error;
    int p0;
    n_cmp++;
    if (O_bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre: got %b want 0", O_bus_error);
    end
    p0      = wr_pulses;
    rd_seen = 0;
    usb_cen = 1'b0;
    usb_rdn = 1'b0;
    usb_wrn = 1'b0;
    idle(6);
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    usb_cen = 1'b1;
    idle(5);
    n_cmp++;
    if (O_bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b want 1", O_bus_error);
    end
    n_cmp++;
    if ({rd_seen, wr_pulses - p0} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL err_no_access: rd %0d wr %0d want 0 0",
               rd_seen, wr_pulses - p0);
    end
    p0 = wr_pulses;
    do_write(21'h00085, 8'h77, 6, 6);
    n_cmp++;
    if ({wr_pulses - p0, write_data, reg_bytecnt}
        !== {32'd1, 8'h77, 7'h05}) begin
      n_fail++;
      $display("FAIL err_recover: n %0d d %h bc %h want 1 77 05",
               wr_pulses - p0, write_data, reg_bytecnt);
    end
    n_cmp++;
    if (O_bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", O_bus_error);
    end
  endtask

  task automatic test_reset_in_hold;
    rd_val   = 8'h99;
    usb_addr = 21'h00200;
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge usb_clk);
      if (usb_isout) break;
    end
    n_cmp++;
    if ({usb_isout, usb_dout} !== {1'b1, 8'h99}) begin
      n_fail++;
      $display("FAIL hold_pre: got %b/%h want 1/99",
               usb_isout, usb_dout);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({usb_isout, reg_read, reg_addrvalid, O_bus_error}
        !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 0000",
               {usb_isout, reg_read, reg_addrvalid,
                O_bus_error});
    end
    usb_rdn = 1'b1;
    usb_cen = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    rd_val   = 8'h3E;
    usb_addr = 21'h00301;
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge usb_clk);
      if (usb_isout) break;
    end
    n_cmp++;
    if ({usb_isout, usb_dout, reg_bytecnt}
        !== {1'b1, 8'h3E, 7'h01}) begin
      n_fail++;
      $display("FAIL read_after_reset: got %b/%h/%h want 1/3e/01",
               usb_isout, usb_dout, reg_bytecnt);
    end
    usb_rdn = 1'b1;
    usb_cen = 1'b1;
    idle(5);
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = wr_pulses;
    bc_q.delete();
    for (int i = 0; i < 8; i++) begin
      do_write(21'h00400 + 21'(i), 8'h10 + 8'(i), 6, 3);
    end
    idle(6);
    n_cmp++;
    if (wr_pulses - p0 !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 8",
               wr_pulses - p0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= bc_q.size()) begin
        n_fail++;
        $display("FAIL b2b_bc%0d: missing pulse want %h",
                 i, 7'(i));
      end else if (bc_q[i] !== 7'(i)) begin
        n_fail++;
        $display("FAIL b2b_bc%0d: got %h want %h",
                 i, bc_q[i], 7'(i));
      end
    end
    n_cmp++;
    if ({write_data, av_bad} !== {8'h17, 32'd0}) begin
      n_fail++;
      $display("FAIL b2b_last: d %h avbad %0d want 17 0",
               write_data, av_bad);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_abort;
    test_bus_error;
    test_reset_in_hold;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
